cci_mpf_prim_ram_rd_stream: RTL and testbench

//  Read-side client for a simple dual-port RAM with fixed read latency. Accepts

---
 rtl/cci_mpf_prim_ram_rd_stream_if.sv | 23 ++
 rtl/cci_mpf_prim_ram_rd_stream.sv | 113 +++++++++++
 tb/tb_cci_mpf_prim_ram_rd_stream.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cci_mpf_prim_ram_rd_stream_if.sv
// Request/response handshake between a consumer pipeline and the RAM read stream.
// master = consumer side, slave = the read-stream block.
interface cci_mpf_prim_ram_rd_stream_if #(
  parameter int N_ADDR_BITS = 5,
  parameter int N_DATA_BITS = 64
);
  logic                   req_en;
  logic [N_ADDR_BITS-1:0] req_addr;
  logic                   req_rdy;
  logic                   rsp_valid;
  logic [N_DATA_BITS-1:0] rsp_data;
  logic                   rsp_deq;

  modport master (
    output req_en, req_addr, rsp_deq,
    input  req_rdy, rsp_valid, rsp_data
  );

  modport slave (
    input  req_en, req_addr, rsp_deq,
    output req_rdy, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cci_mpf_prim_ram_rd_stream.sv
// Credit-managed read client for a fixed-latency simple dual-port RAM with an
// in-order response buffer. Define CCI_MPF_PRIM_RAM_RD_STREAM_BYPASS_EN to let
// RAM data skip an empty buffer and reach rsp_data one cycle earlier.
module cci_mpf_prim_ram_rd_stream #(
  parameter int N_ENTRIES      = 32,
  parameter int N_DATA_BITS    = 64,
  parameter int N_READ_LATENCY = 1,
  parameter int N_BUF_ENTRIES  = N_READ_LATENCY + 2
) (
  input  logic                           clk,
  input  logic                           reset,
  cci_mpf_prim_ram_rd_stream_if.slave    rd,
  output logic [$clog2(N_ENTRIES)-1:0]   ram_raddr,
  input  logic [N_DATA_BITS-1:0]         ram_rdata
);

  localparam int N_CNT_BITS = $clog2(N_BUF_ENTRIES + 1);
  localparam int N_PTR_BITS = $clog2(N_BUF_ENTRIES);

  typedef logic [N_PTR_BITS-1:0] t_ptr;
  typedef logic [N_CNT_BITS-1:0] t_cnt;

  localparam t_ptr LAST_PTR = t_ptr'(N_BUF_ENTRIES - 1);
  localparam t_cnt CNT_MAX  = t_cnt'(N_BUF_ENTRIES);

  // cnt_reg counts every read the buffer must eventually hold: in flight + buffered.
  t_cnt                      cnt_reg;
  t_cnt                      buf_cnt_reg;
  t_ptr                      head_reg;
  t_ptr                      tail_reg;
  logic [N_READ_LATENCY-1:0] valid_pipe_reg;
  logic [N_DATA_BITS-1:0]    buf_mem [N_BUF_ENTRIES];

  logic                      accept;
  logic                      deq_ok;
  logic                      buf_empty;
  logic                      rsp_arrive;
  logic                      buf_wr;
  logic                      buf_rd;
  logic [N_READ_LATENCY:0]   pipe_in;

  function automatic t_ptr next_ptr(input t_ptr p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign ram_raddr  = rd.req_addr;
  assign rd.req_rdy = !reset && (cnt_reg < CNT_MAX);
  assign accept     = rd.req_en && rd.req_rdy;
  assign buf_empty  = (buf_cnt_reg == '0);
  assign rsp_arrive = valid_pipe_reg[N_READ_LATENCY-1];
  assign pipe_in    = {valid_pipe_reg, accept};

`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_BYPASS_EN
  logic rsp_bypass;

  // An arriving response with nothing older buffered goes straight out.
  assign rsp_bypass   = rsp_arrive && buf_empty && !reset;
  assign rd.rsp_valid = !reset && (!buf_empty || rsp_arrive);
  assign rd.rsp_data  = buf_empty ? ram_rdata : buf_mem[head_reg];
  assign deq_ok       = rd.rsp_deq && rd.rsp_valid;
  assign buf_wr       = rsp_arrive && !(rsp_bypass && deq_ok);
  assign buf_rd       = deq_ok && !rsp_bypass;
`else
  assign rd.rsp_valid = !reset && !buf_empty;
  assign rd.rsp_data  = buf_mem[head_reg];
  assign deq_ok       = rd.rsp_deq && rd.rsp_valid;
  assign buf_wr       = rsp_arrive;
  assign buf_rd       = deq_ok;
`endif

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_mem[tail_reg] <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      buf_cnt_reg    <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      valid_pipe_reg <= '0;
    end else begin
      valid_pipe_reg <= pipe_in[N_READ_LATENCY-1:0];

      if (buf_wr) tail_reg <= next_ptr(tail_reg);
      if (buf_rd) head_reg <= next_ptr(head_reg);

      case ({buf_wr, buf_rd})
        2'b10:   buf_cnt_reg <= buf_cnt_reg + 1'b1;
        2'b01:   buf_cnt_reg <= buf_cnt_reg - 1'b1;
        default: buf_cnt_reg <= buf_cnt_reg;
      endcase

      case ({accept, deq_ok})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(buf_wr && !buf_rd && (buf_cnt_reg == CNT_MAX)));
      assert (!(rd.rsp_deq && !rd.rsp_valid));
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_ram_rd_stream.sv
// Bench for cci_mpf_prim_ram_rd_stream: directed vector table, hand sequences and
// randomized traffic checked against a timestamped in-order response queue.
module tb_cci_mpf_prim_ram_rd_stream;

  localparam int NE  = 32;
  localparam int DW  = 32;
  localparam int L   = 2;
  localparam int NB  = L + 2;
  localparam int AW  = $clog2(NE);
`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_BYPASS_EN
  localparam int LAT_EXP = L;
`else
  localparam int LAT_EXP = L + 1;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  cci_mpf_prim_ram_rd_stream_if #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) rd_if ();

  cci_mpf_prim_ram_rd_stream #(
    .N_ENTRIES(NE), .N_DATA_BITS(DW), .N_READ_LATENCY(L), .N_BUF_ENTRIES(NB)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd_if), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: mem[i] = 0xA000 + i, L-cycle registered read
  logic [DW-1:0] mem [NE];
  logic [DW-1:0] rd_pipe [L];
  initial for (int i = 0; i < NE; i++) mem[i] = 32'hA000 + i;
  always @(posedge clk) begin
    rd_pipe[0] <= mem[ram_raddr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // Reference: accepted requests in order, each usable from its ready cycle on.
  typedef struct {
    logic [AW-1:0] addr;
    int            avail;
  } item_t;
  item_t q[$];

  typedef struct {
    bit            en;
    logic [AW-1:0] addr;
    bit            deq;
    bit            exp_rdy;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t tv[17];

  task automatic reset_cycle();
    @(negedge clk);
    reset = 1'b1;
    rd_if.req_en = 1'b0;
    rd_if.req_addr = '0;
    rd_if.rsp_deq = 1'b0;
    #1;
    check("reset_req_rdy", 64'(rd_if.req_rdy), 64'd0);
    check("reset_rsp_valid", 64'(rd_if.rsp_valid), 64'd0);
    q.delete();
  endtask

  task automatic model_cycle(input bit en, input logic [AW-1:0] a, input bit want);
    bit deq;
    bit exp_rdy;
    bit exp_valid;
    @(negedge clk);
    reset = 1'b0;
    rd_if.req_en = en;
    rd_if.req_addr = a;
    #1;
    deq = want && rd_if.rsp_valid;
    rd_if.rsp_deq = deq;
    #1;
    exp_rdy   = (q.size() < NB);
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    check("req_rdy", 64'(rd_if.req_rdy), 64'(exp_rdy));
    check("rsp_valid", 64'(rd_if.rsp_valid), 64'(exp_valid));
    check("ram_raddr", 64'(ram_raddr), 64'(a));
    if (exp_valid) check("rsp_data", 64'(rd_if.rsp_data), 64'(32'hA000 + q[0].addr));
    if (deq && exp_valid) void'(q.pop_front());
    if (en && exp_rdy) q.push_back('{addr: a, avail: cyc + LAT_EXP});
  endtask

  initial begin
    reset = 1'b1;
    rd_if.req_en = 1'b0;
    rd_if.req_addr = '0;
    rd_if.rsp_deq = 1'b0;

    // Single read of addr 5, dequeued the cycle it appears.
    for (int k = 0; k < 6; k++) begin
      tv[k].en        = (k == 0);
      tv[k].addr      = 5'd5;
      tv[k].deq       = (k == LAT_EXP);
      tv[k].exp_rdy   = 1'b1;
      tv[k].exp_valid = (k == LAT_EXP);
      tv[k].exp_data  = 32'hA005;
    end
    // Backpressure: requests every cycle with no deq, then drain four.
    for (int k = 0; k < 11; k++) begin
      tv[6+k].en        = (k < 6);
      tv[6+k].addr      = AW'(16 + k);
      tv[6+k].deq       = (k >= 6) && (k <= 9);
      tv[6+k].exp_rdy   = (k < 4) || (k >= 7);
      tv[6+k].exp_valid = (k >= LAT_EXP) && (k <= 9);
      tv[6+k].exp_data  = 32'hA010 + ((k <= 6) ? 0 : k - 6);
    end

    reset_cycle();
    reset_cycle();

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      reset = 1'b0;
      rd_if.req_en = tv[i].en;
      rd_if.req_addr = tv[i].addr;
      #1;
      rd_if.rsp_deq = tv[i].deq && rd_if.rsp_valid;
      #1;
      check($sformatf("vec%0d_req_rdy", i), 64'(rd_if.req_rdy), 64'(tv[i].exp_rdy));
      check($sformatf("vec%0d_rsp_valid", i), 64'(rd_if.rsp_valid), 64'(tv[i].exp_valid));
      if (tv[i].exp_valid)
        check($sformatf("vec%0d_rsp_data", i), 64'(rd_if.rsp_data), 64'(tv[i].exp_data));
    end

    // Streaming addr 0..7 with deq held.
    reset_cycle();
    for (int i = 0; i < 8; i++) model_cycle(1'b1, AW'(i), 1'b1);
    for (int i = 0; i < LAT_EXP + 2; i++) model_cycle(1'b0, '0, 1'b1);

    // Accept and deq together with three outstanding, then fill to the limit.
    for (int i = 0; i < 3; i++) model_cycle(1'b1, AW'(20 + i), 1'b0);
    for (int i = 0; i < LAT_EXP + 2; i++) model_cycle(1'b0, '0, 1'b0);
    model_cycle(1'b1, AW'(23), 1'b1);
    model_cycle(1'b1, AW'(24), 1'b0);
    model_cycle(1'b1, AW'(25), 1'b0);
    model_cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) model_cycle(1'b0, '0, 1'b1);

    // Reset with three reads in flight; only addr 9 may come back.
    for (int i = 0; i < 3; i++) model_cycle(1'b1, AW'(26 + i), 1'b0);
    reset_cycle();
    model_cycle(1'b1, AW'(9), 1'b1);
    for (int i = 0; i < LAT_EXP + 3; i++) model_cycle(1'b0, '0, 1'b1);

    // Random traffic long enough to wrap the buffer pointers many times.
    for (int i = 0; i < 400; i++)
      model_cycle($urandom_range(0, 3) != 0, AW'($urandom_range(0, NE - 1)),
                  $urandom_range(0, 2) != 0);
    for (int i = 0; i < NB + LAT_EXP + 2; i++) model_cycle(1'b0, '0, 1'b1);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
